// File: rtl/bnn_conv_pool_if.sv
// Handshake and data bundle for the binary conv/pool layer.
// The bench or upstream stage drives the master side; the layer is the slave.
interface bnn_conv_pool_if #(
    parameter int IN_DIM   = 14,
    parameter int IN_CH    = 8,
    parameter int NUM_FILT = 4,
    parameter int POOL_EN  = 1
);
    localparam int OUT_DIM = (POOL_EN != 0) ? IN_DIM / 2 : IN_DIM;

    logic                                 start;
    logic [IN_DIM*IN_DIM*IN_CH-1:0]       pixels;
    logic [NUM_FILT*OUT_DIM*OUT_DIM-1:0]  layer_out;
    logic                                 busy;
    logic                                 done;

    modport master (output start, output pixels, input layer_out, input busy, input done);
    modport slave  (input start, input pixels, output layer_out, output busy, output done);
endinterface

// File: rtl/bnn_conv_pool.sv
// Binary 3x3 XNOR-popcount convolution with per-filter threshold and optional 2x2 OR pool.
// One neighbourhood is evaluated per clock; results land in a registered output map.
module bnn_conv_pool #(
    parameter int IN_DIM   = 14,
    parameter int IN_CH    = 8,
    parameter int NUM_FILT = 4,
    parameter int POOL_EN  = 1,
    localparam int CW      = $clog2(9*IN_CH+1),
    parameter logic [NUM_FILT*9*IN_CH-1:0] WEIGHTS = '0,
    parameter logic [NUM_FILT*CW-1:0]      THRESH  = {NUM_FILT{CW'(41)}}
) (
    input  logic           clk,
    input  logic           rst_n,
    bnn_conv_pool_if.slave bus
);
    localparam int OUT_DIM = (POOL_EN != 0) ? IN_DIM / 2 : IN_DIM;
    localparam int NPOOL   = (POOL_EN != 0) ? 4 : 1;
    localparam int FW      = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int DW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int LW      = NUM_FILT*OUT_DIM*OUT_DIM;

    generate
        if (POOL_EN != 0 && (IN_DIM % 2) != 0) begin : g_bad_dim
            $error("bnn_conv_pool: IN_DIM must be even when POOL_EN=1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   f_q, f_d;
    logic [DW-1:0]   row_q, row_d;
    logic [DW-1:0]   col_q, col_d;
    logic [1:0]      pcnt_q, pcnt_d;
    logic            acc_q, acc_d;
    logic [LW-1:0]   lo_q, lo_d;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    thr;
    logic             conv_bit;
    logic [IN_CH-1:0] pix;
    logic [IN_CH-1:0] wv;
    int               pr, pc, nr, nc, wr_idx;

    // Convolution at the current (filter, position); padding pixels read as 0.
    always_comb begin
        cnt = '0;
        pix = '0;
        wv  = '0;
        nr  = 0;
        nc  = 0;
        pr  = (POOL_EN != 0) ? 2*int'(row_q) + int'(pcnt_q[1]) : int'(row_q);
        pc  = (POOL_EN != 0) ? 2*int'(col_q) + int'(pcnt_q[0]) : int'(col_q);
        for (int k = 0; k < 9; k++) begin
            nr = pr + k/3 - 1;
            nc = pc + k%3 - 1;
            if (nr >= 0 && nr < IN_DIM && nc >= 0 && nc < IN_DIM)
                pix = IN_CH'(bus.pixels >> ((nr*IN_DIM + nc)*IN_CH));
            else
                pix = '0;
            wv  = IN_CH'(WEIGHTS >> ((int'(f_q)*9 + k)*IN_CH));
            cnt = cnt + CW'($countones(~(pix ^ wv)));
        end
        thr      = CW'(THRESH >> (int'(f_q)*CW));
        conv_bit = (cnt > thr);
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        row_d   = row_q;
        col_d   = col_q;
        pcnt_d  = pcnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        wr_idx  = int'(f_q)*OUT_DIM*OUT_DIM + int'(row_q)*OUT_DIM + int'(col_q);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    f_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    pcnt_d  = '0;
                    acc_d   = 1'b0;
                    lo_d    = '0;
                end
            end
            S_RUN: begin
                if (int'(pcnt_q) != NPOOL-1) begin
                    acc_d  = acc_q | conv_bit;
                    pcnt_d = pcnt_q + 2'd1;
                end else begin
                    // Final sub-position of this output pixel: commit and advance col/row/filter.
                    lo_d   = (lo_q & ~(LW'(1) << wr_idx)) | (LW'(acc_q | conv_bit) << wr_idx);
                    pcnt_d = '0;
                    acc_d  = 1'b0;
                    if (int'(col_q) == OUT_DIM-1) begin
                        col_d = '0;
                        if (int'(row_q) == OUT_DIM-1) begin
                            row_d = '0;
                            if (int'(f_q) == NUM_FILT-1) begin
                                f_d     = '0;
                                state_d = S_DONE;
                            end else begin
                                f_d = f_q + FW'(1);
                            end
                        end else begin
                            row_d = row_q + DW'(1);
                        end
                    end else begin
                        col_d = col_q + DW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pcnt_q  <= '0;
            acc_q   <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pcnt_q  <= pcnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.layer_out = lo_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_bnn_conv_pool.sv
// Directed bench for bnn_conv_pool: default geometry, a 4x4 unpooled variant and a hot-pixel filter set.
module tb_bnn_conv_pool;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bnn_conv_pool_if #(.IN_DIM(14), .IN_CH(8), .NUM_FILT(4), .POOL_EN(1)) a_if ();
    bnn_conv_pool_if #(.IN_DIM(4),  .IN_CH(2), .NUM_FILT(1), .POOL_EN(0)) b_if ();
    bnn_conv_pool_if #(.IN_DIM(14), .IN_CH(8), .NUM_FILT(4), .POOL_EN(1)) c_if ();

    bnn_conv_pool u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));

    bnn_conv_pool #(
        .IN_DIM(4), .IN_CH(2), .NUM_FILT(1), .POOL_EN(0),
        .WEIGHTS({18{1'b1}}), .THRESH(5'd9)
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    bnn_conv_pool #(
        .WEIGHTS({4{72'h00000000FF00000000}}), .THRESH({4{7'd64}})
    ) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pass_a(input bit glitch, output int cyc, output logic d0, output logic [195:0] lo0);
        a_if.start = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        d0  = a_if.done;
        lo0 = a_if.layer_out;
        cyc = 0;
        while (a_if.busy && cyc < 2000) begin
            a_if.start = glitch && (cyc == 50 || cyc == 300);
            cyc++;
            @(posedge clk); #1;
        end
        a_if.start = 1'b0;
    endtask

    task automatic pass_b(output int cyc);
        b_if.start = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        cyc = 0;
        while (b_if.busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic pass_c(output int cyc);
        c_if.start = 1'b1;
        @(posedge clk); #1;
        c_if.start = 1'b0;
        cyc = 0;
        while (c_if.busy && cyc < 2000) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int             cyc;
        logic           d0;
        logic [195:0]   lo0;
        logic [195:0]   ones196;
        logic [195:0]   hot_exp;
        logic [1567:0]  hot_px;
        logic [31:0]    b_px  [3];
        logic [15:0]    b_exp [3];

        ones196 = '1;
        hot_exp = '0;
        hot_exp[9] = 1'b1;  hot_exp[58] = 1'b1;
        hot_exp[107] = 1'b1; hot_exp[156] = 1'b1;
        hot_px = '0;
        hot_px[383:376] = 8'hFF;
        b_px[0] = 32'h0000_0C00; b_exp[0] = 16'h0000;
        b_px[1] = 32'hFFFF_FFFF; b_exp[1] = 16'h6FF6;
        b_px[2] = 32'h0000_FFFF; b_exp[2] = 16'h0066;

        a_if.start = 1'b0; a_if.pixels = '0;
        b_if.start = 1'b0; b_if.pixels = '0;
        c_if.start = 1'b0; c_if.pixels = hot_px;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 256'(a_if.busy), 256'(1'b0));
        check("rst_done", 256'(a_if.done), 256'(1'b0));
        check("rst_lo", 256'(a_if.layer_out), 256'(0));
        check("rst_b_busy", 256'(b_if.busy), 256'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero map with zero weights: every position scores 72.
        pass_a(1'b0, cyc, d0, lo0);
        check("zero_cycles", 256'(cyc), 256'(784));
        check("zero_done", 256'(a_if.done), 256'(1'b1));
        check("zero_busy", 256'(a_if.busy), 256'(1'b0));
        check("zero_lo", 256'(a_if.layer_out), 256'(ones196));

        // Restart from DONE with start pulses sprinkled through the run.
        pass_a(1'b1, cyc, d0, lo0);
        check("restart_done_clr", 256'(d0), 256'(1'b0));
        check("restart_lo_clr", 256'(lo0), 256'(0));
        check("glitch_cycles", 256'(cyc), 256'(784));
        check("glitch_done", 256'(a_if.done), 256'(1'b1));
        check("glitch_lo", 256'(a_if.layer_out), 256'(ones196));

        // All-ones map: best case is the corner at 40, never above 41.
        a_if.pixels = '1;
        pass_a(1'b0, cyc, d0, lo0);
        check("ones_cycles", 256'(cyc), 256'(784));
        check("ones_lo", 256'(a_if.layer_out), 256'(0));

        // Abort after 100 busy cycles: 25 pooled bits written so far.
        a_if.pixels = '0;
        a_if.start = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("mid_busy", 256'(a_if.busy), 256'(1'b1));
        check("mid_partial", 256'(a_if.layer_out), 256'(25'h1FF_FFFF));
        rst_n = 1'b0;
        #1;
        check("abort_busy", 256'(a_if.busy), 256'(1'b0));
        check("abort_done", 256'(a_if.done), 256'(1'b0));
        check("abort_lo", 256'(a_if.layer_out), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_abort_idle", 256'(a_if.busy), 256'(1'b0));
        pass_a(1'b0, cyc, d0, lo0);
        check("post_abort_cycles", 256'(cyc), 256'(784));
        check("post_abort_lo", 256'(a_if.layer_out), 256'(ones196));

        // 4x4 unpooled, all-ones weights, threshold 9.
        for (int i = 0; i < 3; i++) begin
            b_if.pixels = b_px[i];
            pass_b(cyc);
            check($sformatf("b_cycles_%0d", i), 256'(cyc), 256'(16));
            check($sformatf("b_lo_%0d", i), 256'(b_if.layer_out), 256'(b_exp[i]));
        end
        check("b_done", 256'(b_if.done), 256'(1'b1));

        // Single hot pixel at (3,5): only the centred window clears 64.
        pass_c(cyc);
        check("hot_cycles", 256'(cyc), 256'(784));
        check("hot_lo", 256'(c_if.layer_out), 256'(hot_exp));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
